dec2_4_pulse: RTL and testbench

Registered 2-to-4 decoder that turns a stream of 2-bit codes into one-hot strobes on four output lines, each held for a programmable number of cycles and followed by a one-cycle all-zero gap. It is the receiving-side counterpart of the 4-to-2 encoder in the codebase's encoder/decoder family. It sits between a code producer, via a valid/ready handshake, and four downstream line consumers that need stretched, clearly separated pulses.

---
 rtl/dec2_4_pulse.sv | 151 +++++++++++++++
 tb/tb_dec2_4_pulse.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec2_4_pulse.sv
// dec2_4_pulse: registered 2-to-4 decoder producing stretched one-hot strobes.
// Each accepted code drives y[code] for HOLD_CYCLES enabled cycles, then a
// one-cycle all-zero GAP (done=1), then IDLE.
// Optional input code FIFO: define DEC24_CODE_FIFO_EN to instantiate a
// FIFO_DEPTH-entry buffer in front of the FSM.
module dec2_4_pulse #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] y,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start;
  logic [1:0]       start_code;

  // Elaboration-time parameter sanity checks
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("dec2_4_pulse: HOLD_CYCLES must be in 1..255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dec2_4_pulse: FIFO_DEPTH must be a power of two, at least 2");
  end

`ifdef DEC24_CODE_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full, empty, push, pop;

  assign full       = (occ_q == OCC_W'(FIFO_DEPTH));
  assign empty      = (occ_q == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign pop        = (state_q == S_IDLE) && en && !empty;
  assign start      = pop;
  assign start_code = mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end
`else
  assign in_ready   = en && (state_q == S_IDLE);
  assign start      = in_valid && in_ready;
  assign start_code = in_code;
`endif

  // Next-state logic and registered-output precompute
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HOLD;
          cnt_d   = CNT_LOAD;
          code_d  = start_code;
        end
      end
      S_HOLD: begin
        if (en) begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    y_d    = (state_d == S_HOLD) ? (4'b0001 << code_d) : 4'b0000;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_GAP);
  end

  // State, counter, latched code and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= 2'd0;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec2_4_pulse.sv
// Scoreboard bench for dec2_4_pulse: accepted codes are queued, a negedge
// monitor checks every strobe (code, enabled length, gap, idle separation).
module tb_dec2_4_pulse;

  localparam int unsigned H_A = 4;
`ifdef DEC24_CODE_FIFO_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid;
  logic [1:0] in_code;
  logic       in_ready, busy, done;
  logic [3:0] y;

  logic       en_b, in_valid_b;
  logic [1:0] in_code_b;
  logic       in_ready_b, busy_b, done_b;
  logic [3:0] y_b;

  dec2_4_pulse #(.HOLD_CYCLES(H_A), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .busy(busy), .done(done)
  );

  dec2_4_pulse #(.HOLD_CYCLES(1), .FIFO_DEPTH(2)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(in_valid_b), .in_code(in_code_b),
    .in_ready(in_ready_b), .y(y_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [1:0] exp_q[$];
  bit         in_strobe = 0;
  bit         post_gap  = 0;
  logic [3:0] cur_y     = 4'b0;
  int         en_cnt    = 0;
  int         len       = 0;
  int         last_len  = 0;
  int         busy_run  = 0;
  int         last_busy = 0;
  int         acc_prev  = 0;
  int         acc_last  = 0;

  // Monitor: pops an expected code whenever a strobe appears and follows it
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      in_strobe = 0;
      post_gap  = 0;
      busy_run  = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
      if (post_gap) begin
        chk("idle_after_gap_y", 32'(y), 32'(0));
        chk("idle_after_gap_done", 32'(done), 32'(0));
        chk("idle_after_gap_busy", 32'(busy), 32'(0));
        post_gap = 0;
      end else if (in_strobe) begin
        if (y != 4'b0) begin
          chk("hold_y", 32'(y), 32'(cur_y));
          chk("hold_busy", 32'(busy), 32'(1));
          chk("hold_done", 32'(done), 32'(0));
          len++;
          if (en) en_cnt++;
        end else begin
          chk("strobe_enabled_cycles", 32'(en_cnt), 32'(H_A));
          chk("gap_done", 32'(done), 32'(1));
          chk("gap_busy", 32'(busy), 32'(1));
          last_len  = len;
          in_strobe = 0;
          post_gap  = 1;
        end
      end else begin
        if (y != 4'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got y=0x%0h expected no strobe", y);
            cur_y = y;
          end else begin
            cur_y = 4'(1 << exp_q.pop_front());
            if (y !== cur_y) begin
              errors++;
              $display("FAIL strobe_code: got y=0x%0h expected 0x%0h", y, cur_y);
            end
          end
          chk("strobe_busy", 32'(busy), 32'(1));
          in_strobe = 1;
          len       = 1;
          en_cnt    = en ? 1 : 0;
        end else begin
          chk("idle_done", 32'(done), 32'(0));
          chk("idle_busy", 32'(busy), 32'(0));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_code);
        acc_prev = acc_last;
        acc_last = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_code  = c;
    #1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_ready_timeout", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !in_strobe && !post_gap && !busy && y == 4'b0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 300), 32'(1));
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (y == 4'b0 && n < 100) begin
      step();
      n++;
    end
    chk("strobe_start_timeout", 32'(y != 4'b0), 32'(1));
  endtask

  initial begin
    bit pend;
    rst_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = 2'd0;
    en_b = 1'b0; in_valid_b = 1'b0; in_code_b = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_y", 32'(y), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_y_h1", 32'(y_b), 32'(0));
    step(); step();
    rst_n = 1'b1;
    en = 1'b1; en_b = 1'b1;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'(1));

    // HOLD_CYCLES=1 instance: code 3
    in_valid_b = 1'b1; in_code_b = 2'd3;
    chk("h1_ready", 32'(in_ready_b), 32'(1));
    step();
    in_valid_b = 1'b0;
    repeat (LAT) step();
    chk("h1_hold_y", 32'(y_b), 32'(4'b1000));
    chk("h1_hold_busy", 32'(busy_b), 32'(1));
    chk("h1_hold_done", 32'(done_b), 32'(0));
    step();
    chk("h1_gap_y", 32'(y_b), 32'(0));
    chk("h1_gap_done", 32'(done_b), 32'(1));
`ifndef DEC24_CODE_FIFO_EN
    chk("h1_gap_ready", 32'(in_ready_b), 32'(0));
`endif
    step();
    chk("h1_idle_ready", 32'(in_ready_b), 32'(1));
    chk("h1_idle_done", 32'(done_b), 32'(0));
    chk("h1_idle_busy", 32'(busy_b), 32'(0));

    // Each code singly
    for (int c = 0; c < 4; c++) begin
      send(2'(c));
      wait_drain();
      chk("single_len", 32'(last_len), 32'(H_A));
      chk("single_busy_cycles", 32'(last_busy), 32'(H_A + 1));
    end

    // Back-to-back with in_valid held high
    send(2'd2);
    send(2'd1);
`ifdef DEC24_CODE_FIFO_EN
    chk("b2b_accept_spacing", 32'(acc_last - acc_prev), 32'(1));
`else
    chk("b2b_accept_spacing", 32'(acc_last - acc_prev), 32'(H_A + 2));
`endif
    wait_drain();

    // en low for 3 cycles mid-HOLD stretches the strobe
    send(2'd0);
    wait_strobe();
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    wait_drain();
    chk("freeze_len", 32'(last_len), 32'(H_A + 3));

    // en low in IDLE
    en = 1'b0; in_valid = 1'b1; in_code = 2'd3;
    #1;
`ifdef DEC24_CODE_FIFO_EN
    chk("en0_idle_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    step(); step();
    chk("en0_no_pop_y", 32'(y), 32'(0));
`else
    for (int i = 0; i < 3; i++) begin
      chk("en0_idle_ready", 32'(in_ready), 32'(0));
      step();
    end
    in_valid = 1'b0;
    chk("en0_no_start_y", 32'(y), 32'(0));
`endif
    en = 1'b1;
    wait_drain();

`ifdef DEC24_CODE_FIFO_EN
    // FIFO: three consecutive pushes while idle
    in_valid = 1'b1; in_code = 2'd3; #1;
    chk("fifo_push0_ready", 32'(in_ready), 32'(1));
    step(); in_code = 2'd0;
    chk("fifo_push1_ready", 32'(in_ready), 32'(1));
    step(); in_code = 2'd1;
    chk("fifo_push2_ready", 32'(in_ready), 32'(1));
    step(); in_valid = 1'b0;
    chk("fifo_full_ready", 32'(in_ready), 32'(0));
    wait_drain();
`endif

    // Asynchronous reset mid-HOLD
    send(2'd2);
    wait_strobe();
    step();
    chk("pre_reset_y", 32'(y), 32'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_y", 32'(y), 32'(0));
    chk("async_reset_busy", 32'(busy), 32'(0));
    chk("async_reset_done", 32'(done), 32'(0));
    step(); step();
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    chk("ready_after_release", 32'(in_ready), 32'(1));

    // Randomized traffic with protocol-respecting holds
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if (!pend) begin
        in_valid = 1'($urandom_range(0, 1));
        in_code  = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      pend = in_valid && !in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    en = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
